// File: rtl/neuron_slot_gen_if.sv
// Bundle for neuron_slot_gen: run/config inputs plus the slot-timing outputs.
// slave  : the generator (consumes en/half_cnt/num_neurons/tap_idx, drives the rest)
// master : whatever drives the configuration and observes the slot outputs
interface neuron_slot_gen_if #(
  parameter int CNT_W    = 32,
  parameter int IDX_W    = 7,
  parameter int NUM_TAPS = 4,
  parameter int FRM_W    = 16
);
  logic                      en;
  logic [CNT_W-1:0]          half_cnt;
  logic [IDX_W-1:0]          num_neurons;
  logic [NUM_TAPS*IDX_W-1:0] tap_idx;
  logic                      slow_clk;
  logic                      tick;
  logic                      phase;
  logic [IDX_W-1:0]          neuron_idx;
  logic                      frame_start;
  logic [NUM_TAPS-1:0]       tap_strb;
  logic                      tap_any;
  logic [FRM_W-1:0]          frame_cnt;

  modport slave (
    input  en, half_cnt, num_neurons, tap_idx,
    output slow_clk, tick, phase, neuron_idx, frame_start, tap_strb, tap_any, frame_cnt
  );

  modport master (
    output en, half_cnt, num_neurons, tap_idx,
    input  slow_clk, tick, phase, neuron_idx, frame_start, tap_strb, tap_any, frame_cnt
  );
endinterface

// File: rtl/neuron_slot_gen.sv
// Neuron slot generator. Divides rawclk into slow_clk (50% duty, half-period
// half_cnt+1 cycles) with a one-cycle enable tick on each rising slow edge,
// and on every tick issues the next (neuron_idx, phase) slot of a frame of
// max(num_neurons,1) neurons, two phases each. Frame and tap strobes accompany
// the issuing tick; frame_cnt counts completed frames.
// Ports:
//   rawclk - sole clock
//   reset  - synchronous active-high reset
//   bus    - neuron_slot_gen_if.slave: en, half_cnt, num_neurons, tap_idx in;
//            slow_clk, tick, phase, neuron_idx, frame_start, tap_strb,
//            tap_any, frame_cnt out (all registered)
module neuron_slot_gen #(
  parameter int CNT_W    = 32,
  parameter int IDX_W    = 7,
  parameter int NUM_TAPS = 4,
  parameter int FRM_W    = 16
) (
  input logic               rawclk,
  input logic               reset,
  neuron_slot_gen_if.slave  bus
);

  logic [CNT_W-1:0]    delay_cnt;
  logic [CNT_W-1:0]    half_q;
  logic [IDX_W-1:0]    nn_q;
  logic                slow_q;
  logic                tick_q;
  logic [IDX_W-1:0]    nxt_idx;
  logic                nxt_phase;
  logic [IDX_W-1:0]    idx_q;
  logic                phase_q;
  logic                frame_start_q;
  logic [NUM_TAPS-1:0] tap_strb_q;
  logic                tap_any_q;
  logic [FRM_W-1:0]    frame_cnt_q;

  logic [IDX_W-1:0]    nn_eff;
  logic [NUM_TAPS-1:0] tap_hit;
  logic                last_idx;

  // 0 and 1 both mean a single-neuron frame
  assign nn_eff   = (bus.num_neurons == '0) ? IDX_W'(1) : bus.num_neurons;
  // >= rather than == so an index stranded past a shrunken frame still wraps
  assign last_idx = (nxt_idx >= (nn_q - IDX_W'(1)));

  always_comb begin
    tap_hit = '0;
    for (int unsigned i = 0; i < NUM_TAPS; i++) begin
      tap_hit[i] = (nxt_idx == bus.tap_idx[i*IDX_W +: IDX_W]);
    end
  end

  always_ff @(posedge rawclk) begin
    if (reset) begin
      delay_cnt     <= '0;
      half_q        <= bus.half_cnt;
      nn_q          <= nn_eff;
      slow_q        <= 1'b0;
      tick_q        <= 1'b0;
      nxt_idx       <= '0;
      nxt_phase     <= 1'b0;
      idx_q         <= '0;
      phase_q       <= 1'b0;
      frame_start_q <= 1'b0;
      tap_strb_q    <= '0;
      tap_any_q     <= 1'b0;
      frame_cnt_q   <= '0;
    end else if (bus.en) begin
      tick_q        <= 1'b0;
      frame_start_q <= 1'b0;
      tap_strb_q    <= '0;
      if (delay_cnt < half_q) begin
        delay_cnt <= delay_cnt + CNT_W'(1);
      end else begin
        delay_cnt <= '0;
        slow_q    <= ~slow_q;
        half_q    <= bus.half_cnt;
        if (!slow_q) begin
          // rising slow edge: issue the pending slot and advance the pointer
          tick_q        <= 1'b1;
          idx_q         <= nxt_idx;
          phase_q       <= nxt_phase;
          frame_start_q <= (nxt_idx == '0) && !nxt_phase;
          tap_strb_q    <= nxt_phase ? '0 : tap_hit;
          tap_any_q     <= |tap_hit;
          if (!nxt_phase) begin
            nxt_phase <= 1'b1;
          end else begin
            nxt_phase <= 1'b0;
            if (last_idx) begin
              nxt_idx     <= '0;
              frame_cnt_q <= frame_cnt_q + FRM_W'(1);
              nn_q        <= nn_eff;
            end else begin
              nxt_idx <= nxt_idx + IDX_W'(1);
            end
          end
        end
      end
    end
  end

  assign bus.slow_clk    = slow_q;
  assign bus.tick        = tick_q;
  assign bus.phase       = phase_q;
  assign bus.neuron_idx  = idx_q;
  assign bus.frame_start = frame_start_q;
  assign bus.tap_strb    = tap_strb_q;
  assign bus.tap_any     = tap_any_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_neuron_slot_gen.sv
module tb_neuron_slot_gen;
  localparam int CNT_W    = 32;
  localparam int IDX_W    = 7;
  localparam int NUM_TAPS = 4;
  localparam int FRM_W    = 16;

  logic rawclk = 1'b0;
  logic reset  = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  always #5 rawclk = ~rawclk;

  neuron_slot_gen_if #(.CNT_W(CNT_W), .IDX_W(IDX_W), .NUM_TAPS(NUM_TAPS), .FRM_W(FRM_W)) bus ();

  neuron_slot_gen #(.CNT_W(CNT_W), .IDX_W(IDX_W), .NUM_TAPS(NUM_TAPS), .FRM_W(FRM_W)) dut (
    .rawclk (rawclk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one rawclk edge, then settle to a sampling point 1 time unit after it
  task automatic step();
    @(posedge rawclk);
    #1;
  endtask

  // steps until tick is seen, bounded; n = number of edges taken
  task automatic wait_tick(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.tick !== 1'b1 && n < 200);
    chk(tag, bus.tick, 1);
  endtask

  task automatic chk_slot(input string tag, input int idx, input int ph, input int fs);
    chk({tag, "_idx"}, bus.neuron_idx, idx);
    chk({tag, "_ph"},  bus.phase, ph);
    chk({tag, "_fs"},  bus.frame_start, fs);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_slow"}, bus.slow_clk, 0);
    chk({tag, "_tick"}, bus.tick, 0);
    chk({tag, "_idx"},  bus.neuron_idx, 0);
    chk({tag, "_ph"},   bus.phase, 0);
    chk({tag, "_fs"},   bus.frame_start, 0);
    chk({tag, "_strb"}, bus.tap_strb, 0);
    chk({tag, "_any"},  bus.tap_any, 0);
    chk({tag, "_fcnt"}, bus.frame_cnt, 0);
  endtask

  // reset with the given settings held, then release with en=1 so the next edge is edge 1
  task automatic do_reset(input int h, input int nn);
    reset           = 1'b1;
    bus.en          = 1'b0;
    bus.half_cnt    = CNT_W'(h);
    bus.num_neurons = IDX_W'(nn);
    step();
    step();
    reset  = 1'b0;
    bus.en = 1'b1;
  endtask

  int n;
  int exp_idx [11];
  int exp_ph  [11];
  int exp_fs  [11];
  int tap_ix  [7];
  int tap_ph  [7];
  int tap_s   [7];
  int tap_a   [7];

  initial begin
    bus.en          = 1'b0;
    bus.half_cnt    = '0;
    bus.num_neurons = '0;
    bus.tap_idx     = {7'd7, 7'd7, 7'd7, 7'd7};

    // ---------------- basic divide: H=3, 4 neurons
    do_reset(3, 4);
    chk_reset_vals("rst");
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("pre_tick", bus.tick, 0);
      chk("pre_slow", bus.slow_clk, 0);
    end
    step(); // edge 4
    chk("t1_tick", bus.tick, 1);
    chk("t1_slow", bus.slow_clk, 1);
    chk_slot("t1", 0, 0, 1);
    for (int i = 5; i <= 8; i++) begin
      step();
      chk("t1_tickclr", bus.tick, 0);
      chk("t1_fsclr", bus.frame_start, 0);
      chk("slow_hi", bus.slow_clk, (i < 8) ? 1 : 0);
    end
    exp_idx = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 0, 0};
    exp_ph  = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
    exp_fs  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    for (int k = 0; k < 8; k++) begin
      wait_tick("basic_tick", n);
      chk("basic_period", n, (k == 0) ? 4 : 8);
      chk_slot("basic", exp_idx[k], exp_ph[k], exp_fs[k]);
      if (k == 5) chk("fcnt_before", bus.frame_cnt, 0);
      if (k == 6) chk("fcnt_tick8", bus.frame_cnt, 1);
    end

    // ---------------- taps: {7,2,2,0}, 3 neurons, H=1
    bus.tap_idx = {7'd7, 7'd2, 7'd2, 7'd0};
    do_reset(1, 3);
    tap_ix = '{0, 0, 1, 1, 2, 2, 0};
    tap_ph = '{0, 1, 0, 1, 0, 1, 0};
    tap_s  = '{1, 0, 0, 0, 6, 0, 1};
    tap_a  = '{1, 1, 0, 0, 1, 1, 1};
    for (int k = 0; k < 7; k++) begin
      wait_tick("tap_tick", n);
      chk_slot("tap", tap_ix[k], tap_ph[k], (k == 0 || k == 6) ? 1 : 0);
      chk("tap_strb", bus.tap_strb, tap_s[k]);
      chk("tap_any", bus.tap_any, tap_a[k]);
      step();
      chk("tap_strb_clr", bus.tap_strb, 0);
      chk("tap_any_hold", bus.tap_any, tap_a[k]);
    end

    // ---------------- live changes: H 3->1 mid-half, nn 4->2 mid-frame
    bus.tap_idx = {7'd7, 7'd7, 7'd7, 7'd7};
    do_reset(3, 4);
    wait_tick("live_t1", n);
    chk("live_first", n, 4);
    step();
    bus.half_cnt = CNT_W'(1);
    wait_tick("live_t2", n);
    chk("live_stretch", n, 5);
    chk_slot("live2", 0, 1, 0);
    bus.num_neurons = IDX_W'(2);
    exp_idx = '{1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 0};
    exp_ph  = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    exp_fs  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    for (int k = 0; k < 11; k++) begin
      wait_tick("live_tick", n);
      chk("live_period", n, 4);
      chk_slot("live", exp_idx[k], exp_ph[k], exp_fs[k]);
    end
    chk("live_fcnt", bus.frame_cnt, 2);

    // ---------------- enable gap while tick is high
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("gap_tick", bus.tick, 1);
      chk("gap_slow", bus.slow_clk, 1);
      chk_slot("gap", 0, 0, 1);
      chk("gap_fcnt", bus.frame_cnt, 2);
    end
    bus.en = 1'b1;
    step();
    chk("resume_tickclr", bus.tick, 0);
    chk("resume_fsclr", bus.frame_start, 0);
    wait_tick("resume_tick", n);
    chk("resume_period", n, 3);
    chk_slot("resume1", 0, 1, 0);
    wait_tick("resume_tick2", n);
    chk("resume_period2", n, 4);
    chk_slot("resume2", 1, 0, 0);

    // ---------------- degenerate: H=0, nn=0
    do_reset(0, 0);
    for (int k = 0; k < 6; k++) begin
      wait_tick("deg_tick", n);
      chk("deg_period", n, (k == 0) ? 1 : 2);
      chk_slot("deg", 0, k % 2, (k % 2 == 0) ? 1 : 0);
    end
    chk("deg_fcnt", bus.frame_cnt, 3);

    // ---------------- reset mid-frame at (2,1)
    do_reset(1, 4);
    for (int k = 0; k < 6; k++) wait_tick("mid_tick", n);
    chk_slot("mid_pre", 2, 1, 0);
    reset = 1'b1;
    step();
    chk_reset_vals("midrst");
    reset = 1'b0;
    wait_tick("post_rst_tick", n);
    chk("post_rst_lat", n, 2);
    chk_slot("post_rst", 0, 0, 1);
    chk("post_rst_fcnt", bus.frame_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/neuron_slot_gen.md
# neuron_slot_gen

Parametrised successor to the neuron-loop clock generator. Divides `rawclk` into a slow neuron clock and a matching single-cycle enable `tick`, then sequences a two-phase neuron index over a programmable frame length. It raises frame and tap strobes at configurable neuron indices. Everything runs in the `rawclk` domain, so downstream neuron pipelines use `tick` as an enable instead of clocking on a derived clock.

## Interface
Parameters:
- `CNT_W`, 32, width of the half-period divider.
- `IDX_W`, 7, width of the neuron index.
- `NUM_TAPS`, 4, number of programmable tap indices.
- `FRM_W`, 16, width of the frame counter.

Ports:
- `rawclk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable. Low freezes all state.
- `half_cnt`  in  CNT_W  half-period minus one, in `rawclk` cycles.
- `num_neurons`  in  IDX_W  neurons per frame. 0 and 1 both mean 1.
- `tap_idx`  in  NUM_TAPS*IDX_W  tap i occupies bits `[i*IDX_W +: IDX_W]`.
- `slow_clk`  out  1  divided clock, 50% duty.
- `tick`  out  1  one-cycle pulse on each 0->1 transition of `slow_clk`.
- `phase`  out  1  sub-slot of the current neuron (0, then 1).
- `neuron_idx`  out  IDX_W  neuron currently issued.
- `frame_start`  out  1  pulse with the `tick` that issues neuron 0, phase 0.
- `tap_strb`  out  NUM_TAPS  bit i pulses with the phase-0 `tick` of neuron `tap_idx[i]`.
- `tap_any`  out  1  level. High for both slow periods of any tapped neuron.
- `frame_cnt`  out  FRM_W  completed-frame count, wraps.

## Operation
- **Reset values.** `reset` high at a `rawclk` edge sets:
  - `delay_cnt=0`, `slow_clk=0`, `tick=0`.
  - Issue pointer `{nxt_idx, nxt_phase}=0`.
  - `neuron_idx=0`, `phase=0`.
  - `frame_start=0`, `tap_strb=0`, `tap_any=0`, `frame_cnt=0`.
  - Latches `half_q<=half_cnt` and `nn_q<=max(num_neurons,1)`.
- **Reset priority.** Reset overrides `en` and can arrive mid-frame. Nothing survives it.
- **Divider.**
  - Acts only while `en=1`.
  - If `delay_cnt < half_q`: `delay_cnt++`.
  - Otherwise: `delay_cnt<=0`, `slow_clk` toggles, and `half_q<=half_cnt`. A new divisor therefore takes effect only at a half-period boundary.
  - `half_cnt=0` toggles on every enabled cycle.
- **Tick.** `tick<=1` exactly on the edge where `slow_clk` goes 0->1. Otherwise `tick<=0`.
- **Issue on every tick.**
  - `neuron_idx<=nxt_idx` and `phase<=nxt_phase`.
  - `frame_start<=(nxt_idx==0 && nxt_phase==0)`.
  - `tap_strb[i]<=(nxt_phase==0 && nxt_idx==tap_idx[i])`.
  - `tap_any<=OR_i(nxt_idx==tap_idx[i])`, held until the next tick.
- **Pointer advance on every tick.**
  - If `nxt_phase` is 0, it becomes 1.
  - Otherwise `nxt_phase<=0`, and `nxt_idx` advances:
    - If `nxt_idx >= nn_q-1`: `nxt_idx<=0`, `frame_cnt++` (wraps at 2^FRM_W), and `nn_q<=max(num_neurons,1)`.
    - Else `nxt_idx++`.
  - The `>=` compare covers an index left beyond the frame length.
- **Strobe clearing.** On non-tick cycles, `frame_start` and `tap_strb` are 0.
- **Duplicate taps.** Taps at the same index all fire together.
- **Out-of-range taps.** A tap at an index `>= nn_q` never fires.
- **`en` low.** Every register holds, including a `tick` that is currently high, which is cleared on the next enabled edge. Resuming continues the count with no lost or extra ticks.

## Timing
- Edge 1 is the first `rawclk` edge with `reset=0` and `en=1`, with `en` held high. Let `H=half_q`.
- `slow_clk` rises after edge H+1 and falls after edge 2(H+1). Period is 2(H+1) cycles.
- `tick` is high in the cycle after edges H+1, 3(H+1), 5(H+1), and so on.
- The first tick after reset issues neuron 0, phase 0, with `frame_start=1`.
- All outputs are registered. There is zero combinational path from inputs to outputs.
- A frame is 2·`nn_q` ticks.

## Test plan
- **Basic divide.** Reset, then `half_cnt=3`, `num_neurons=4`, `en=1`. Required:
  - `slow_clk` period is 8 cycles.
  - First `tick` follows edge 4.
  - Tick sequence `(idx,phase)` = (0,0)(0,1)(1,0)(1,1)…(3,1)(0,0).
  - `frame_start` pulses on ticks 1 and 9.
  - `frame_cnt` reaches 1 after tick 8.
- **Taps.** `tap_idx={7,2,2,0}`, `num_neurons=3`. Required:
  - Tap 0 pulses at idx 0 phase 0.
  - Taps 1 and 2 pulse together at idx 2.
  - Tap 3 never pulses.
  - `tap_any` is high across idx 0 and idx 2, and low across idx 1.
- **Live parameter change.** Change `half_cnt` 3->1 mid-half-period. Required: the current half-period finishes at 4 cycles, then half-periods are 2 cycles. Change `num_neurons` 4->2 mid-frame. Required: the current frame completes through idx 3, and the next frame wraps after idx 1.
- **Enable gaps.** Drop `en` for 5 cycles, including the cycle where `tick` is high. Required: all outputs are frozen, and the tick sequence resumes with no skip or duplicate.
- **Degenerate settings.** `half_cnt=0` with `num_neurons=0`. Required: `tick` every 2 cycles, `neuron_idx` stays at 0, and `frame_start` fires on every second tick.
- **Reset mid-frame.** Assert `reset` for 1 cycle at idx 2 phase 1. Required: every output returns to its reset value on the next edge, and the next tick issues (0,0) with `frame_start`.
